// File: rtl/dbus_responder_pkg.sv
// Shared types for the data-bus responder: size encodings, bus payloads,
// and the alignment rule used by the responder.
package dbus_responder_pkg;

  localparam int unsigned AddrW   = 32;
  localparam int unsigned WordW   = 32;
  localparam int unsigned StrobeW = WordW / 8;
  localparam int unsigned SizeW   = 3;

  typedef logic [AddrW-1:0]   addr_t;
  typedef logic [WordW-1:0]   word_t;
  typedef logic [StrobeW-1:0] strobe_t;

  typedef enum logic [SizeW-1:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
    logic  err;
  } dbus_resp_t;

  // Alignment check; unknown size encodings are treated as word accesses.
  function automatic logic isMisaligned(msize_t size, logic [1:0] byteOff);
    logic mis;
    case (size)
      MSIZE1:  mis = 1'b0;
      MSIZE2:  mis = byteOff[0];
      default: mis = (byteOff != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dbus_word_ram.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// A write and a read of the same word in one cycle returns the old word.
module dbus_word_ram
  import dbus_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  strobe_t               strobe,
  input  word_t                 wdata,
  output word_t                 rdata
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  word_t mem [Depth];

  // Byte-masked write plus registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < int'(StrobeW); i++) begin
        if (strobe[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Responder end of the data-bus request interface: accepts one request at a
// time, waits LATENCY cycles and answers with a single-cycle data_ok.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned CntW        = 4;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);
  localparam bit SingleCycle          = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  dbus_req_t  req;
  dbus_resp_t resp;

  state_t                state;
  logic [CntW-1:0]       cnt;
  logic                  dataOkQ;
  logic                  errQ;

  logic [ADDR_WIDTH-1:0] idxQ;
  strobe_t               strobeQ;
  word_t                 wdataQ;
  logic                  misQ;

  logic                  accept;
  logic                  reqMis;
  logic                  ramRd;
  logic                  ramWr;
  logic                  ramEn;
  logic [ADDR_WIDTH-1:0] ramIdx;
  strobe_t               ramStrobe;
  word_t                 ramRdata;
  logic                  unusedAddr;

  assign req = '{
    valid:  req_valid,
    addr:   req_addr,
    size:   msize_t'(req_size),
    strobe: req_strobe,
    data:   req_data
  };

  // Upper address bits alias onto the RAM and are deliberately dropped.
  assign unusedAddr = ^req.addr[AddrW-1:ADDR_WIDTH+2];

  assign accept = (state == IDLE) && req.valid && !reset;
  assign reqMis = isMisaligned(req.size, req.addr[1:0]);

  // Control FSM with latency counter; data_ok/err registers load on entry to RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      dataOkQ <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      dataOkQ <= 1'b0;
      errQ    <= 1'b0;
      case (state)
        IDLE: begin
          if (req.valid) begin
            cnt <= CntLoad;
            if (SingleCycle) begin
              state   <= RESP;
              dataOkQ <= 1'b1;
              errQ    <= reqMis;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CntW'(1);
          if (cnt == CntW'(1)) begin
            state   <= RESP;
            dataOkQ <= 1'b1;
            errQ    <= misQ;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Capture the accepted request; held until the response cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      idxQ    <= req.addr[ADDR_WIDTH+1:2];
      strobeQ <= req.strobe;
      wdataQ  <= req.data;
      misQ    <= reqMis;
    end
  end

  // RAM port control: read one cycle ahead of RESP, write during RESP.
  always_comb begin
    ramRd     = 1'b0;
    ramWr     = 1'b0;
    ramIdx    = idxQ;
    ramStrobe = '0;
    if (state == IDLE) begin
      ramIdx = req.addr[ADDR_WIDTH+1:2];
      ramRd  = SingleCycle && req.valid;
    end
    if ((state == WAIT) && (cnt == CntW'(1))) begin
      ramRd = 1'b1;
    end
    if ((state == RESP) && !misQ && !reset) begin
      ramWr     = 1'b1;
      ramStrobe = strobeQ;
    end
    ramEn = ramRd || ramWr;
  end

  dbus_word_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ramEn),
    .idx   (ramIdx),
    .strobe(ramStrobe),
    .wdata (wdataQ),
    .rdata (ramRdata)
  );

  // Response bundle; a reset landing on the response cycle suppresses it.
  always_comb begin
    resp         = '0;
    resp.addr_ok = (state == IDLE) && req.valid && !reset;
    resp.data_ok = dataOkQ && !reset;
    resp.err     = errQ && !reset;
    resp.data    = (dataOkQ && !errQ && !reset) ? ramRdata : '0;
  end

  assign resp_addr_ok = resp.addr_ok;
  assign resp_data_ok = resp.data_ok;
  assign resp_data    = resp.data;
  assign resp_err     = resp.err;

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: directed vector table, multi-cycle corner
// sequences and randomized traffic against a word-array reference model.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  localparam logic [2:0] S1 = MSIZE1;
  localparam logic [2:0] S2 = MSIZE2;
  localparam logic [2:0] S4 = MSIZE4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [3:0]  strobe;
  logic [31:0] wdata;
  logic        valid0, valid1;
  logic        aok0, aok1, dok0, dok1, err0, err1;
  logic [31:0] rdata0, rdata1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: LATENCY=2, instance 1: LATENCY=1.
  dbus_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .req_valid(valid0), .req_addr(addr),
    .req_size(size), .req_strobe(strobe), .req_data(wdata),
    .resp_addr_ok(aok0), .resp_data_ok(dok0), .resp_data(rdata0), .resp_err(err0));

  dbus_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_addr(addr),
    .req_size(size), .req_strobe(strobe), .req_data(wdata),
    .resp_addr_ok(aok1), .resp_data_ok(dok1), .resp_data(rdata1), .resp_err(err1));

  function automatic int lat(input int sel);
    return (sel == 0) ? 2 : 1;
  endfunction
  function automatic logic getAok(input int sel);
    return (sel == 0) ? aok0 : aok1;
  endfunction
  function automatic logic getDok(input int sel);
    return (sel == 0) ? dok0 : dok1;
  endfunction
  function automatic logic getErr(input int sel);
    return (sel == 0) ? err0 : err1;
  endfunction
  function automatic logic [31:0] getData(input int sel);
    return (sel == 0) ? rdata0 : rdata1;
  endfunction

  task automatic setValid(input int sel, input logic v);
    if (sel == 0) valid0 = v;
    else valid1 = v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One full transaction; entered and left mid-cycle after a falling edge.
  task automatic doReq(input int sel, input logic [31:0] a, input logic [2:0] sz,
                       input logic [3:0] st, input logic [31:0] d,
                       output logic [31:0] gotData, output logic gotErr);
    int k;
    bit seen;
    addr = a; size = sz; strobe = st; wdata = d;
    setValid(sel, 1'b1);
    #1;
    check("addr_ok_on_request", 32'(getAok(sel)), 32'd1);
    k = 0;
    while (!getAok(sel) && k < 20) begin
      @(negedge clk); #2;
      k++;
    end
    @(posedge clk);
    @(negedge clk); #2;
    setValid(sel, 1'b0);
    k = 1;
    seen = 1'b0;
    while (k <= 40) begin
      if (getDok(sel)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk); #2;
      k++;
    end
    check("data_ok_latency", seen ? 32'(k) : 32'd0, 32'(lat(sel)));
    gotData = getData(sel);
    gotErr  = getErr(sel);
    @(negedge clk); #2;
    check("data_ok_one_cycle", 32'(getDok(sel)), 32'd0);
    check("err_cleared_after", 32'(getErr(sel)), 32'd0);
    check("data_cleared_after", getData(sel), 32'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [2:0]  sz;
    logic [3:0]  st;
    logic [31:0] d;
    bit          chk;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] mdl [2][16];

  initial begin
    logic [31:0] gd;
    logic        ge;
    logic [8:0]  aokMask, dokMask;
    logic [31:0] busyData;

    reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
    addr = '0; size = S4; strobe = '0; wdata = '0;

    tbl.push_back('{32'h10,   S4,   4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{32'h10,   S4,   4'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{32'h12,   S1,   4'h4, 32'h00AA0000, 1'b1, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{32'h10,   S4,   4'h0, 32'h0,        1'b1, 32'hDEAABEEF, 1'b0});
    tbl.push_back('{32'h13,   S4,   4'hF, 32'h11111111, 1'b1, 32'h0,        1'b1});
    tbl.push_back('{32'h10,   S4,   4'h0, 32'h0,        1'b1, 32'hDEAABEEF, 1'b0});
    tbl.push_back('{32'h11,   S2,   4'h0, 32'h0,        1'b1, 32'h0,        1'b1});
    tbl.push_back('{32'h12,   S2,   4'h0, 32'h0,        1'b1, 32'hDEAABEEF, 1'b0});
    tbl.push_back('{32'h10,   3'd7, 4'h0, 32'h0,        1'b1, 32'hDEAABEEF, 1'b0});
    tbl.push_back('{32'h12,   3'd5, 4'h0, 32'h0,        1'b1, 32'h0,        1'b1});
    tbl.push_back('{32'h13,   S1,   4'h0, 32'h0,        1'b1, 32'hDEAABEEF, 1'b0});
    tbl.push_back('{32'h20,   S4,   4'hF, 32'h0,        1'b0, 32'h0,        1'b0});
    tbl.push_back('{32'h1004, S4,   4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{32'h0004, S4,   4'h0, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0});

    // Reset state.
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk); #2;
    check("reset_data_ok0", 32'(dok0), 32'd0);
    check("reset_data_ok1", 32'(dok1), 32'd0);
    check("reset_err0", 32'(err0), 32'd0);
    check("reset_data0", rdata0, 32'd0);
    check("reset_addr_ok0", 32'(aok0), 32'd0);

    // Directed table on both latencies.
    for (int sel = 0; sel < 2; sel++) begin
      foreach (tbl[i]) begin
        doReq(sel, tbl[i].a, tbl[i].sz, tbl[i].st, tbl[i].d, gd, ge);
        check($sformatf("vec%0d_lat%0d_err", i, lat(sel)), 32'(ge), 32'(tbl[i].expErr));
        if (tbl[i].chk)
          check($sformatf("vec%0d_lat%0d_data", i, lat(sel)), gd, tbl[i].expData);
      end
    end

    // Request held while busy: read 0x10 at T0, write 0x30 held from T1.
    addr = 32'h10; size = S4; strobe = 4'h0; wdata = '0; valid0 = 1'b1;
    #1;
    check("busy_first_accept", 32'(aok0), 32'd1);
    aokMask = '0; dokMask = '0; busyData = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #2;
      if (c == 1) begin addr = 32'h30; strobe = 4'hF; wdata = 32'h55AA55AA; end
      if (c == 4) valid0 = 1'b0;
      #1;
      aokMask[c] = aok0;
      dokMask[c] = dok0;
      if (c == 2) busyData = rdata0;
    end
    check("busy_addr_ok_pattern", 32'(aokMask), 32'h008);
    check("busy_data_ok_pattern", 32'(dokMask), 32'h024);
    check("busy_first_data", busyData, 32'hDEAABEEF);
    @(negedge clk); #2;
    doReq(0, 32'h30, S4, 4'h0, 32'h0, gd, ge);
    check("busy_second_write_data", gd, 32'h55AA55AA);

    // Reset during WAIT drops the write to 0x20.
    addr = 32'h20; size = S4; strobe = 4'hF; wdata = 32'h12345678; valid0 = 1'b1;
    #1;
    check("rst_wait_accept", 32'(aok0), 32'd1);
    @(posedge clk);
    @(negedge clk); #2;
    valid0 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #2;
    check("rst_wait_data_ok", 32'(dok0), 32'd0);
    check("rst_wait_data", rdata0, 32'd0);
    check("rst_wait_err", 32'(err0), 32'd0);
    dokMask = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #2;
      dokMask[c] = dok0;
    end
    check("rst_wait_no_late_ok", 32'(dokMask), 32'd0);
    doReq(0, 32'h20, S4, 4'h0, 32'h0, gd, ge);
    check("rst_wait_mem_kept", gd, 32'h0);

    // Reset coinciding with RESP: data_ok forced low, no write.
    addr = 32'h20; size = S4; strobe = 4'hF; wdata = 32'h9999AAAA; valid0 = 1'b1;
    #1;
    check("rst_resp_accept", 32'(aok0), 32'd1);
    @(posedge clk);
    @(negedge clk); #2;
    valid0 = 1'b0;
    @(negedge clk); #2;
    check("rst_resp_pre", 32'(dok0), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_resp_forced", 32'(dok0), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #2;
    check("rst_resp_after", 32'(dok0), 32'd0);
    doReq(0, 32'h20, S4, 4'h0, 32'h0, gd, ge);
    check("rst_resp_no_write", gd, 32'h0);

    // Randomized traffic on words 0x100..0x10F with random aliasing bits.
    for (int sel = 0; sel < 2; sel++) begin
      for (int w = 0; w < 16; w++) begin
        logic [31:0] d;
        d = $urandom;
        doReq(sel, 32'((256 + w) * 4), S4, 4'hF, d, gd, ge);
        check("rand_init_err", 32'(ge), 32'd0);
        mdl[sel][w] = d;
      end
      for (int n = 0; n < 120; n++) begin
        int          w;
        logic [31:0] a, d, expData;
        logic [2:0]  sz;
        logic [3:0]  st;
        logic        expErr;
        w  = $urandom_range(0, 15);
        a  = ($urandom & 32'hFFFFF000) | 32'((256 + w) * 4) | 32'($urandom_range(0, 3));
        sz = 3'($urandom_range(0, 7));
        st = 4'($urandom);
        d  = $urandom;
        if (sz == S1)      expErr = 1'b0;
        else if (sz == S2) expErr = a[0];
        else               expErr = (a[1:0] != 2'b00);
        expData = expErr ? 32'h0 : mdl[sel][w];
        doReq(sel, a, sz, st, d, gd, ge);
        check($sformatf("rand_lat%0d_a%h_err", lat(sel), a), 32'(ge), 32'(expErr));
        check($sformatf("rand_lat%0d_a%h_data", lat(sel), a), gd, expData);
        if (!expErr) begin
          for (int b = 0; b < 4; b++)
            if (st[b]) mdl[sel][w][8*b +: 8] = d[8*b +: 8];
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
